halut_decoder_array: RTL and testbench
======================================

// Module: halut_decoder_array
// PURPOSE
// - Halut LUT decoder: one row of C encoded codebook indices (c,k) in, DecoderUnits column sums out.
// - Holds DecoderUnits column LUTs; each stores C*K signed entries.
// - Sits after the encoder. Every row it accumulates lut[m][c*K+k] over c=0..C-1 for all m in parallel.
// - It then streams the DecoderUnits 32-bit results out serially, one per cycle, tagged with m.
// PARAMETERS
// - DecoderUnits    16   number of output columns (LUTs/accumulators); power of 2
// - K               16   prototypes per codebook; power of 2
// - C               32   codebooks per row; power of 2; must satisfy C >= DecoderUnits
// - DataTypeWidth   16   LUT entry width, signed two's complement
// - DecAddrWidth    $clog2(DecoderUnits)   derived
// - TotalAddrWidth  $clog2(C*K)            derived
// - CAddrWidth      $clog2(C)              derived
// - TreeDepth       $clog2(K)              derived
// PORTS
// - clk_i      in   1               single clock, rising edge
// - rst_i      in   1               asynchronous, active-high reset
// - m_addr_i   in   DecAddrWidth    LUT select for a write
// - waddr_i    in   TotalAddrWidth  LUT write address = c*K+k
// - wdata_i    in   DataTypeWidth   LUT write data
// - we_i       in   1               LUT write enable
// - c_addr_i   in   CAddrWidth      codebook index of the input beat
// - k_addr_i   in   TreeDepth       prototype index chosen by the encoder
// - decoder_i  in   1               input beat valid
// - result_o   out  32              signed column sum
// - valid_o    out  1               result_o/m_addr_o valid this cycle
// - m_addr_o   out  DecAddrWidth    column index of result_o
// BEHAVIOUR
// - Reset (async, rst_i=1):
//   - valid_o=0, result_o=0, m_addr_o=0.
//   - All accumulators, output buffer and stream counter are cleared.
//   - LUT contents are not reset.
// - Write: on a clk edge with we_i=1, LUT[m_addr_i][waddr_i] <= wdata_i. Writes are legal at any time.
// - Read: all DecoderUnits LUTs read address c_addr_i*K+k_addr_i synchronously when decoder_i=1.
//   - Data is available the next cycle (stage 1).
//   - A same-cycle write to the same address returns the old data.
// - Accumulate (stage 2): for each m, the entry is sign-extended to 32 bits.
//   - If the beat's c==0: acc[m] = entry. Otherwise acc[m] += entry.
//   - Add wraps modulo 2^32; no saturation.
//   - Cycles with decoder_i=0 leave acc unchanged. Gaps between beats are allowed.
// - Row completion: when the beat with c==C-1 is accumulated, the final sums (including that beat) are copied into the output buffer.
//   - The serial stream then starts.
//   - c order is not checked; only c==0 (restart) and c==C-1 (finish) are special.
// - Latency: beat c==C-1 at edge t -> valid_o=1 on cycles t+2 .. t+1+DecoderUnits.
//   - m_addr_o counts 0,1,..,DecoderUnits-1 over those cycles; result_o = buffer[m_addr_o].
//   - valid_o=0 otherwise.
// - Back-to-back rows: C >= DecoderUnits, so a stream always ends before the next row completes.
//   - If a new completion arrives mid-stream anyway, the buffer is overwritten and the stream restarts at m=0.
// - Reset mid-row or mid-stream: partial sums and the stream are discarded.
//   - Output resumes only after a fresh c==0..C-1 row.
// - No backpressure: the consumer must accept one result per cycle while valid_o=1.
// TESTING
// - Reset: rst_i=1 mid-stream -> valid_o=0, result_o=0, m_addr_o=0 immediately; no further valid_o until a new full row.
// - Identity LUTs: LUT[m][c*K+k]=m+1 for all c,k; one row c=0..31 with any k -> 16 cycles valid_o, m_addr_o=0..15, result_o=32*(m+1).
// - Negative/sign-ext: LUT[m][c*K+3]=16'hFFFF (-1); row with all k=3 -> result_o=32'hFFFFFFE0 (-32) for every m.
// - Index select: LUT[m][c*K+k]=k*100+c; row with k=c%16 -> result_o=sum over c of ((c%16)*100+c) = 24496, for every m.
// - Gaps + back-to-back rows: decoder_i toggled 1/0 within row 1, row 2 starting the cycle after row 1's last beat -> sums unaffected by gaps; row 2 c==0 restarts acc; two clean 16-cycle streams.
// - Write/read collision: write LUT[0][5] (new value) at the same edge as a read of address 5 -> old value accumulated; the next row uses the new value.

Source files
------------

// File: rtl/halut_decoder_array.sv
// halut_decoder_array
// Halut LUT decoder. Each input beat (c,k) selects entry c*K+k in every one of
// DecoderUnits column LUTs. The entries are summed per column over a row
// (c=0 restarts the sums, c=C-1 closes the row). Finished sums are latched into
// an output buffer and streamed out one column per cycle, tagged with m.
module halut_decoder_array #(
    parameter int DecoderUnits  = 16,
    parameter int K             = 16,
    parameter int C             = 32,
    parameter int DataTypeWidth = 16,
    localparam int DecAddrWidth   = $clog2(DecoderUnits),
    localparam int TotalAddrWidth = $clog2(C * K),
    localparam int CAddrWidth     = $clog2(C),
    localparam int TreeDepth      = $clog2(K)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [DecAddrWidth-1:0]         m_addr_i,
    input  logic [TotalAddrWidth-1:0]       waddr_i,
    input  logic signed [DataTypeWidth-1:0] wdata_i,
    input  logic                            we_i,
    input  logic [CAddrWidth-1:0]           c_addr_i,
    input  logic [TreeDepth-1:0]            k_addr_i,
    input  logic                            decoder_i,
    output logic signed [31:0]              result_o,
    output logic                            valid_o,
    output logic [DecAddrWidth-1:0]         m_addr_o
);

    localparam int LutDepth = C * K;
    localparam int AccW     = 32;

    // Widen a LUT entry to accumulator width, preserving its sign.
    function automatic logic signed [AccW-1:0] sign_extend(input logic [DataTypeWidth-1:0] v);
        return {{(AccW - DataTypeWidth){v[DataTypeWidth-1]}}, v};
    endfunction

    // Accumulator add; the carry out is dropped so sums wrap modulo 2^32.
    function automatic logic signed [AccW-1:0] add_wrap(input logic signed [AccW-1:0] a,
                                                        input logic signed [AccW-1:0] b);
        return a + b;
    endfunction

    // ---- stage 0: LUT read address (C and K are powers of two, so c*K+k is a concatenation)
    logic [TotalAddrWidth-1:0] raddr_p0;
    assign raddr_p0 = {c_addr_i, k_addr_i};

    // ---- stage 1: per-column LUT read data
    logic [DecoderUnits-1:0][DataTypeWidth-1:0] rd_p1;

    for (genvar g = 0; g < DecoderUnits; g++) begin : g_lut
        logic [DataTypeWidth-1:0] mem [LutDepth];
        logic [DataTypeWidth-1:0] rd_q;

        // Column LUT write port; contents are intentionally not cleared by reset.
        always_ff @(posedge clk_i) begin
            if (we_i && (m_addr_i == DecAddrWidth'(g))) begin
                mem[waddr_i] <= wdata_i;
            end
        end

        // Synchronous read; a same-edge write to this address is seen only by later reads.
        always_ff @(posedge clk_i) begin
            if (decoder_i) begin
                rd_q <= mem[raddr_p0];
            end
        end

        assign rd_p1[g] = rd_q;
    end

    logic vld_p1;
    logic first_p1;
    logic last_p1;

    // Beat control travelling alongside the read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            vld_p1   <= decoder_i;
            first_p1 <= (c_addr_i == '0);
            last_p1  <= (c_addr_i == CAddrWidth'(C - 1));
        end
    end

    // ---- stage 2: accumulate, and latch finished rows into the output buffer
    logic signed [AccW-1:0] acc_p2 [DecoderUnits];
    logic signed [AccW-1:0] sum_p1 [DecoderUnits];
    logic signed [AccW-1:0] obuf   [DecoderUnits];
    logic                   row_done;

    assign row_done = vld_p1 && last_p1;

    // Next accumulator value: c==0 restarts the sum, any other c adds on.
    always_comb begin
        for (int m = 0; m < DecoderUnits; m++) begin
            sum_p1[m] = first_p1 ? sign_extend(rd_p1[m])
                                 : add_wrap(acc_p2[m], sign_extend(rd_p1[m]));
        end
    end

    // Accumulators advance only on valid beats; the closing beat also fills the buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int m = 0; m < DecoderUnits; m++) begin
                acc_p2[m] <= '0;
                obuf[m]   <= '0;
            end
        end else if (vld_p1) begin
            for (int m = 0; m < DecoderUnits; m++) begin
                acc_p2[m] <= sum_p1[m];
                if (last_p1) begin
                    obuf[m] <= sum_p1[m];
                end
            end
        end
    end

    // ---- output stream: one buffered column per cycle
    logic                    stream_active;
    logic [DecAddrWidth-1:0] stream_cnt;

    // Stream sequencer; a new completion always restarts the walk at column 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stream_active <= 1'b0;
            stream_cnt    <= '0;
        end else if (row_done) begin
            stream_active <= 1'b1;
            stream_cnt    <= '0;
        end else if (stream_active) begin
            if (stream_cnt == DecAddrWidth'(DecoderUnits - 1)) begin
                stream_active <= 1'b0;
                stream_cnt    <= '0;
            end else begin
                stream_cnt <= stream_cnt + DecAddrWidth'(1);
            end
        end
    end

    assign valid_o  = stream_active;
    assign m_addr_o = stream_cnt;
    assign result_o = stream_active ? obuf[stream_cnt] : '0;

endmodule

// File: tb/tb_halut_decoder_array.sv
// tb_halut_decoder_array
// Randomised bench for halut_decoder_array. A behavioural model keeps a copy of
// every LUT write and computes each row's column sums as plain integer sums;
// streamed outputs are captured with their cycle number and compared against
// the expected (m, sum, cycle) sequence.
module tb_halut_decoder_array;

    localparam int DU = 16;
    localparam int K  = 16;
    localparam int C  = 32;
    localparam int N  = C * K;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [3:0]  wr_m    = '0;
    logic [8:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_en   = 1'b0;
    logic [4:0]  c_addr  = '0;
    logic [3:0]  k_addr  = '0;
    logic        beat    = 1'b0;
    logic [31:0] result;
    logic        valid;
    logic [3:0]  out_m;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic signed [15:0] lut_m [DU][N];
    int row_k   [C];
    int exp_sum [DU];
    int sum_a   [DU];
    int t_last  = 0;
    int exp_m[$], exp_r[$], exp_t[$];
    int cap_m[$], cap_r[$], cap_t[$];

    halut_decoder_array #(
        .DecoderUnits (DU),
        .K            (K),
        .C            (C),
        .DataTypeWidth(16)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .m_addr_i (wr_m),
        .waddr_i  (wr_addr),
        .wdata_i  (wr_data),
        .we_i     (wr_en),
        .c_addr_i (c_addr),
        .k_addr_i (k_addr),
        .decoder_i(beat),
        .result_o (result),
        .valid_o  (valid),
        .m_addr_o (out_m)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every streamed result with the cycle it appeared in.
    always @(negedge clk) begin
        if (valid) begin
            cap_m.push_back(int'(out_m));
            cap_r.push_back(int'(result));
            cap_t.push_back(cyc);
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic lut_write(input int m, input int a, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_m    = 4'(m);
        wr_addr = 9'(a);
        wr_data = 16'(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        lut_m[m][a] = 16'(d);
    endtask

    task automatic send_beat(input int c, input int k);
        @(negedge clk);
        beat   = 1'b1;
        c_addr = 5'(c);
        k_addr = 4'(k);
        @(posedge clk);
        #1;
        beat   = 1'b0;
        t_last = cyc;
    endtask

    // Beat and LUT write presented on the same clock edge.
    task automatic send_beat_with_write(input int c, input int k, input int m, input int a, input int d);
        @(negedge clk);
        beat    = 1'b1;
        c_addr  = 5'(c);
        k_addr  = 4'(k);
        wr_en   = 1'b1;
        wr_m    = 4'(m);
        wr_addr = 9'(a);
        wr_data = 16'(d);
        @(posedge clk);
        #1;
        beat   = 1'b0;
        wr_en  = 1'b0;
        t_last = cyc;
        lut_m[m][a] = 16'(d);
    endtask

    task automatic random_ks();
        for (int c = 0; c < C; c++) row_k[c] = $urandom_range(0, K - 1);
    endtask

    // Reference: each column's sum over the row of its selected entries.
    task automatic model_row();
        for (int m = 0; m < DU; m++) begin
            exp_sum[m] = 0;
            for (int c = 0; c < C; c++) exp_sum[m] += int'(lut_m[m][c * K + row_k[c]]);
        end
    endtask

    task automatic drive_row(input bit gaps);
        for (int c = 0; c < C; c++) begin
            if (gaps && (c == 10 || $urandom_range(0, 2) == 0))
                repeat ($urandom_range(1, 3)) @(posedge clk);
            send_beat(c, row_k[c]);
        end
    endtask

    task automatic expect_stream(input int t0);
        for (int i = 0; i < DU; i++) begin
            exp_m.push_back(i);
            exp_r.push_back(exp_sum[i]);
            exp_t.push_back(t0 + i);
        end
    endtask

    task automatic wait_outputs(input int budget);
        for (int i = 0; i < budget && cap_r.size() < exp_r.size(); i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_queues();
        exp_m.delete(); exp_r.delete(); exp_t.delete();
        cap_m.delete(); cap_r.delete(); cap_t.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b, expected 0", valid); end
        tests++;
        if (result !== 32'd0) begin failed++; $display("FAIL reset_result: got %h, expected 0", result); end
        tests++;
        if (out_m !== 4'd0) begin failed++; $display("FAIL reset_m_addr: got %0d, expected 0", out_m); end
        rst = 1'b0;
        clear_queues();
        repeat (6) @(negedge clk);
        tests++;
        if (cap_r.size() != 0) begin failed++; $display("FAIL reset_idle: got %0d results, expected 0", cap_r.size()); end
    endtask

    task automatic test_identity();
        for (int m = 0; m < DU; m++)
            for (int a = 0; a < N; a++) lut_write(m, a, m + 1);
        clear_queues();
        random_ks();
        drive_row(1'b0);
        for (int m = 0; m < DU; m++) exp_sum[m] = 32 * (m + 1);
        expect_stream(t_last + 1);
        wait_outputs(60);
        tests++;
        if (cap_r.size() != exp_r.size()) begin failed++; $display("FAIL identity_count: got %0d results, expected %0d", cap_r.size(), exp_r.size()); end
        for (int i = 0; i < exp_r.size() && i < cap_r.size(); i++) begin
            tests++;
            if (cap_m[i] !== exp_m[i] || cap_r[i] !== exp_r[i] || cap_t[i] !== exp_t[i]) begin
                failed++;
                $display("FAIL identity[%0d]: got m=%0d result=%0d cycle=%0d, expected m=%0d result=%0d cycle=%0d", i, cap_m[i], cap_r[i], cap_t[i], exp_m[i], exp_r[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_sign_ext();
        for (int m = 0; m < DU; m++)
            for (int c = 0; c < C; c++) lut_write(m, c * K + 3, 'hFFFF);
        clear_queues();
        for (int c = 0; c < C; c++) row_k[c] = 3;
        drive_row(1'b0);
        for (int m = 0; m < DU; m++) exp_sum[m] = -32;
        expect_stream(t_last + 1);
        wait_outputs(60);
        tests++;
        if (cap_r.size() != exp_r.size()) begin failed++; $display("FAIL sign_ext_count: got %0d results, expected %0d", cap_r.size(), exp_r.size()); end
        for (int i = 0; i < exp_r.size() && i < cap_r.size(); i++) begin
            tests++;
            if (cap_m[i] !== exp_m[i] || cap_r[i] !== exp_r[i] || cap_t[i] !== exp_t[i]) begin
                failed++;
                $display("FAIL sign_ext[%0d]: got m=%0d result=%0d cycle=%0d, expected m=%0d result=%0d cycle=%0d", i, cap_m[i], cap_r[i], cap_t[i], exp_m[i], exp_r[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_index_select();
        for (int m = 0; m < DU; m++)
            for (int c = 0; c < C; c++) lut_write(m, c * K + (c % 16), (c % 16) * 100 + c);
        clear_queues();
        for (int c = 0; c < C; c++) row_k[c] = c % 16;
        drive_row(1'b1);
        for (int m = 0; m < DU; m++) exp_sum[m] = 24496;
        expect_stream(t_last + 1);
        wait_outputs(60);
        tests++;
        if (cap_r.size() != exp_r.size()) begin failed++; $display("FAIL index_count: got %0d results, expected %0d", cap_r.size(), exp_r.size()); end
        for (int i = 0; i < exp_r.size() && i < cap_r.size(); i++) begin
            tests++;
            if (cap_m[i] !== exp_m[i] || cap_r[i] !== exp_r[i] || cap_t[i] !== exp_t[i]) begin
                failed++;
                $display("FAIL index[%0d]: got m=%0d result=%0d cycle=%0d, expected m=%0d result=%0d cycle=%0d", i, cap_m[i], cap_r[i], cap_t[i], exp_m[i], exp_r[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        random_ks();
        model_row();
        drive_row(1'b1);
        expect_stream(t_last + 1);
        random_ks();
        model_row();
        drive_row(1'b0);
        expect_stream(t_last + 1);
        wait_outputs(80);
        tests++;
        if (cap_r.size() != exp_r.size()) begin failed++; $display("FAIL b2b_count: got %0d results, expected %0d", cap_r.size(), exp_r.size()); end
        for (int i = 0; i < exp_r.size() && i < cap_r.size(); i++) begin
            tests++;
            if (cap_m[i] !== exp_m[i] || cap_r[i] !== exp_r[i] || cap_t[i] !== exp_t[i]) begin
                failed++;
                $display("FAIL b2b[%0d]: got m=%0d result=%0d cycle=%0d, expected m=%0d result=%0d cycle=%0d", i, cap_m[i], cap_r[i], cap_t[i], exp_m[i], exp_r[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_collision();
        lut_write(0, 5, 'h0123);
        clear_queues();
        random_ks();
        row_k[0] = 5;
        model_row();
        send_beat_with_write(0, 5, 0, 5, 'h7A00);
        for (int c = 1; c < C; c++) send_beat(c, row_k[c]);
        expect_stream(t_last + 1);
        model_row();
        drive_row(1'b0);
        expect_stream(t_last + 1);
        wait_outputs(80);
        tests++;
        if (cap_r.size() != exp_r.size()) begin failed++; $display("FAIL collision_count: got %0d results, expected %0d", cap_r.size(), exp_r.size()); end
        for (int i = 0; i < exp_r.size() && i < cap_r.size(); i++) begin
            tests++;
            if (cap_m[i] !== exp_m[i] || cap_r[i] !== exp_r[i] || cap_t[i] !== exp_t[i]) begin
                failed++;
                $display("FAIL collision[%0d]: got m=%0d result=%0d cycle=%0d, expected m=%0d result=%0d cycle=%0d", i, cap_m[i], cap_r[i], cap_t[i], exp_m[i], exp_r[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_random_rows();
        int d;
        clear_queues();
        for (int r = 0; r < 3; r++) begin
            random_ks();
            for (int c = 0; c < C; c++)
                for (int m = 0; m < DU; m++) begin
                    case ($urandom_range(0, 7))
                        0:       d = 'h8000;
                        1:       d = 'h7FFF;
                        default: d = $urandom_range(0, 65535);
                    endcase
                    lut_write(m, c * K + row_k[c], d);
                end
            model_row();
            drive_row(1'b1);
            expect_stream(t_last + 1);
        end
        wait_outputs(80);
        tests++;
        if (cap_r.size() != exp_r.size()) begin failed++; $display("FAIL random_count: got %0d results, expected %0d", cap_r.size(), exp_r.size()); end
        for (int i = 0; i < exp_r.size() && i < cap_r.size(); i++) begin
            tests++;
            if (cap_m[i] !== exp_m[i] || cap_r[i] !== exp_r[i] || cap_t[i] !== exp_t[i]) begin
                failed++;
                $display("FAIL random[%0d]: got m=%0d result=%0d cycle=%0d, expected m=%0d result=%0d cycle=%0d", i, cap_m[i], cap_r[i], cap_t[i], exp_m[i], exp_r[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_restart_mid_stream();
        int t_a;
        int ka;
        int kb;
        clear_queues();
        random_ks();
        model_row();
        drive_row(1'b0);
        t_a = t_last;
        for (int m = 0; m < DU; m++) sum_a[m] = exp_sum[m];
        ka = $urandom_range(0, K - 1);
        kb = $urandom_range(0, K - 1);
        repeat (2) @(posedge clk);
        send_beat(0, ka);
        send_beat(C - 1, kb);
        for (int i = 0; i < t_last - t_a; i++) begin
            exp_m.push_back(i);
            exp_r.push_back(sum_a[i]);
            exp_t.push_back(t_a + 1 + i);
        end
        for (int m = 0; m < DU; m++)
            exp_sum[m] = int'(lut_m[m][ka]) + int'(lut_m[m][(C - 1) * K + kb]);
        expect_stream(t_last + 1);
        wait_outputs(60);
        tests++;
        if (cap_r.size() != exp_r.size()) begin failed++; $display("FAIL restart_count: got %0d results, expected %0d", cap_r.size(), exp_r.size()); end
        for (int i = 0; i < exp_r.size() && i < cap_r.size(); i++) begin
            tests++;
            if (cap_m[i] !== exp_m[i] || cap_r[i] !== exp_r[i] || cap_t[i] !== exp_t[i]) begin
                failed++;
                $display("FAIL restart[%0d]: got m=%0d result=%0d cycle=%0d, expected m=%0d result=%0d cycle=%0d", i, cap_m[i], cap_r[i], cap_t[i], exp_m[i], exp_r[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        clear_queues();
        random_ks();
        model_row();
        drive_row(1'b0);
        for (int i = 0; i < 40 && cap_r.size() < 5; i++) @(negedge clk);
        tests++;
        if (cap_r.size() < 5) begin failed++; $display("FAIL rst_stream_start: got %0d results, expected at least 5", cap_r.size()); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (valid !== 1'b0) begin failed++; $display("FAIL rst_mid_valid: got %b, expected 0", valid); end
        tests++;
        if (result !== 32'd0) begin failed++; $display("FAIL rst_mid_result: got %h, expected 0", result); end
        tests++;
        if (out_m !== 4'd0) begin failed++; $display("FAIL rst_mid_m_addr: got %0d, expected 0", out_m); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_queues();
        repeat (40) @(negedge clk);
        tests++;
        if (cap_r.size() != 0) begin failed++; $display("FAIL rst_stream_dropped: got %0d results, expected 0", cap_r.size()); end
        // reset in the middle of a row, then a fresh full row
        random_ks();
        for (int c = 0; c < C / 2; c++) send_beat(c, row_k[c]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        tests++;
        if (cap_r.size() != 0) begin failed++; $display("FAIL rst_row_dropped: got %0d results, expected 0", cap_r.size()); end
        clear_queues();
        random_ks();
        model_row();
        drive_row(1'b1);
        expect_stream(t_last + 1);
        wait_outputs(60);
        tests++;
        if (cap_r.size() != exp_r.size()) begin failed++; $display("FAIL rst_recover_count: got %0d results, expected %0d", cap_r.size(), exp_r.size()); end
        for (int i = 0; i < exp_r.size() && i < cap_r.size(); i++) begin
            tests++;
            if (cap_m[i] !== exp_m[i] || cap_r[i] !== exp_r[i] || cap_t[i] !== exp_t[i]) begin
                failed++;
                $display("FAIL rst_recover[%0d]: got m=%0d result=%0d cycle=%0d, expected m=%0d result=%0d cycle=%0d", i, cap_m[i], cap_r[i], cap_t[i], exp_m[i], exp_r[i], exp_t[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_sign_ext();
        test_index_select();
        test_back_to_back();
        test_collision();
        test_random_rows();
        test_restart_mid_stream();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
